bitwise_accum: RTL and testbench

BITWISE_ACCUM -- requirements
Module: bitwise_accum

---
 rtl/bitwise_accum.sv | 121 ++++++++++++
 tb/tb_bitwise_accum.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_accum.sv
// Frame accumulator: folds up to COUNT operands with AND/OR/XOR/NAND.
// Ports: in_* valid/ready operand stream, out_* valid/ready result.
module bitwise_accum #(
  parameter  int WIDTH = 16,
  parameter  int COUNT = 4,
  localparam int CW    = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [1:0]       op;
  logic [1:0]       op_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [CW-1:0]    cnt_out_nxt;
  logic [WIDTH-1:0] folded;
  logic [CW-1:0]    count_inc;
  logic             live;
  logic             fire;

  // live keeps in_ready low until the first edge after reset release
  assign in_ready  = live && (state != DONE);
  assign out_valid = (state == DONE);
  assign fire      = in_valid && in_ready;
  assign count_inc = count + CW'(1);

  always_comb begin
    folded = acc & in_data;
    unique case (op)
      OP_OR:   folded = acc | in_data;
      OP_XOR:  folded = acc ^ in_data;
      default: folded = acc & in_data;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    op_nxt      = op;
    count_nxt   = count;
    data_nxt    = out_data;
    cnt_out_nxt = out_count;
    unique case (state)
      IDLE: begin
        if (fire) begin
          acc_nxt   = in_data;
          op_nxt    = in_op;
          count_nxt = CW'(1);
          if (in_last) begin
            state_nxt   = DONE;
            data_nxt    = (in_op == OP_NAND) ? ~in_data : in_data;
            cnt_out_nxt = CW'(1);
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (fire) begin
          acc_nxt   = folded;
          count_nxt = count_inc;
          if (in_last || count_inc == CW'(COUNT)) begin
            state_nxt   = DONE;
            data_nxt    = (op == OP_NAND) ? ~folded : folded;
            cnt_out_nxt = count_inc;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      op        <= 2'b00;
      count     <= '0;
      out_data  <= '0;
      out_count <= '0;
      live      <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      op        <= op_nxt;
      count     <= count_nxt;
      out_data  <= data_nxt;
      out_count <= cnt_out_nxt;
      live      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bitwise_accum.sv
// Self-checking bench for bitwise_accum (WIDTH=16, COUNT=4).
// Table vectors, directed corner sequences, random frames vs model.
module tb_bitwise_accum;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_op;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitwise_accum #(.WIDTH(W), .COUNT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_op(in_op),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count)
  );

  typedef struct {
    logic [1:0]        op;
    logic [1:0]        opx;
    int                n;
    logic [3:0][W-1:0] d;
    bit                last;
    logic [W-1:0]      ed;
    logic [CW-1:0]     ec;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Leaves time at 1 unit after the edge that accepted the final beat.
  task automatic send_frame(input logic [1:0] op, input logic [1:0] opx,
                            input int n, input logic [3:0][W-1:0] d,
                            input bit last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        int g = $urandom_range(0, 2);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_last  = 1'($urandom);
        for (int k = 0; k < g; k++) step();
      end
      wait_ready();
      in_valid = 1'b1;
      in_data  = d[i];
      in_op    = (i == 0) ? op : opx;
      in_last  = last && (i == n - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(input string name, input int hold);
    logic [W-1:0]  hd = out_data;
    logic [CW-1:0] hc = out_count;
    for (int k = 0; k < hold; k++) begin
      step();
      chk({name, "_hold"},
          {12'd0, out_valid, in_ready, hc, hd},
          {12'd0, 1'b1, 1'b0, out_count, out_data});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_after"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic run_frame(input string name, input vec_t v,
                           input bit gaps, input int hold);
    send_frame(v.op, v.opx, v.n, v.d, v.last, gaps);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, {16'd0, out_data}, {16'd0, v.ed});
    chk({name, "_count"}, {29'd0, out_count}, {29'd0, v.ec});
    consume(name, hold);
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op,
                                         input logic [3:0][W-1:0] d,
                                         input int n);
    logic [W-1:0] r = d[0];
    for (int i = 1; i < n; i++) begin
      if (op == 2'b01)      r = r | d[i];
      else if (op == 2'b10) r = r ^ d[i];
      else                  r = r & d[i];
    end
    return (op == 2'b11) ? ~r : r;
  endfunction

  initial begin
    vecs[0] = '{2'b01, 2'b01, 4, {16'h0008, 16'h0004, 16'h0002, 16'h0001},
                1'b0, 16'h000F, 3'd4};
    vecs[1] = '{2'b00, 2'b00, 2, {16'h0, 16'h0, 16'h0FFF, 16'hFF0F},
                1'b1, 16'h0F0F, 3'd2};
    vecs[2] = '{2'b10, 2'b00, 3, {16'h0, 16'h0F0F, 16'hFFFF, 16'hAAAA},
                1'b1, 16'h5A5A, 3'd3};
    vecs[3] = '{2'b11, 2'b11, 1, {16'h0, 16'h0, 16'h0, 16'h0000},
                1'b1, 16'hFFFF, 3'd1};
    vecs[4] = '{2'b11, 2'b01, 3, {16'h0, 16'hF000, 16'hFF00, 16'hF0F0},
                1'b1, 16'h0FFF, 3'd3};
    vecs[5] = '{2'b00, 2'b10, 4, {16'h1FFF, 16'h3FFF, 16'h7FFF, 16'hFFFF},
                1'b0, 16'h1FFF, 3'd4};
    vecs[6] = '{2'b10, 2'b10, 4, {16'h8888, 16'h4444, 16'h2222, 16'h1111},
                1'b1, 16'hFFFF, 3'd4};
    vecs[7] = '{2'b01, 2'b11, 1, {16'h0, 16'h0, 16'h0, 16'h1234},
                1'b1, 16'h1234, 3'd1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("reset_outs", {out_valid, in_ready, 11'd0, out_count, out_data},
        32'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
    step();
    chk("ready_after_edge", {30'd0, in_ready, out_valid}, 32'd2);

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), vecs[i], 1'b0, 0);

    run_frame("backpressure", vecs[1], 1'b0, 5);

    send_frame(2'b01, 2'b01, 2, {16'h0, 16'h0, 16'h0002, 16'h0001},
               1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs",
        {out_valid, in_ready, 11'd0, out_count, out_data}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midreset_nopulse", {31'd0, out_valid}, 32'd0);
    end
    run_frame("post_reset", vecs[7], 1'b0, 0);

    for (int f = 0; f < 40; f++) begin
      vec_t v;
      v.op   = 2'($urandom);
      v.opx  = 2'($urandom);
      v.last = 1'($urandom);
      v.n    = v.last ? int'($urandom_range(1, 4)) : 4;
      for (int i = 0; i < 4; i++) v.d[i] = W'($urandom);
      v.ed   = model(v.op, v.d, v.n);
      v.ec   = CW'(v.n);
      run_frame($sformatf("rand%0d", f), v, 1'b1,
                int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
